// File: rtl/keccak_state_unloader_pkg.sv
// Shared definitions for the Keccak state unloader: FSM encoding, default geometry,
// and the lane-count helper.
package keccak_state_unloader_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   localparam int unsigned DefaultSize = 1600;
   localparam int unsigned DefaultWord = 64;

   function automatic int unsigned lane_count(input int unsigned size, input int unsigned word);
      return size / word;
   endfunction

endpackage

// File: rtl/keccak_state_unloader.sv
// Captures a full Keccak state in one cycle and drains it as WORD-bit lanes,
// least-significant lane first, over a valid/ready stream.
module keccak_state_unloader
   import keccak_state_unloader_pkg::*;
#(
   parameter int unsigned SIZE = DefaultSize,
   parameter int unsigned WORD = DefaultWord
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [SIZE-1:0] i_v_data,
   input  logic            i_v_load,
   output logic            o_busy,
   output logic [WORD-1:0] o_v_word,
   output logic            o_valid,
   input  logic            i_ready,
   output logic            o_last,
   output logic            o_done
);

   localparam int unsigned NWORDS = lane_count(SIZE, WORD);
   localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(NWORDS - 1);

   state_e          state_q, state_d;
   logic [SIZE-1:0] sreg_q, sreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      o_busy   = 1'b0;
      o_valid  = 1'b0;
      o_last   = 1'b0;
      o_v_word = '0;
      unique case (state_q)
         StIdle: begin
            if (i_v_load) begin
               sreg_d  = i_v_data;
               cnt_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            o_busy   = 1'b1;
            o_valid  = 1'b1;
            o_v_word = sreg_q[WORD-1:0];
            o_last   = (cnt_q == LastIdx);
            if (i_ready) begin
               if (o_last) begin
                  // Final lane leaves the shift register untouched; o_v_word is gated in IDLE.
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  sreg_d = sreg_q >> WORD;
                  cnt_d  = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_done = done_q;

endmodule

// File: tb/tb_keccak_state_unloader.sv
// Self-checking bench for keccak_state_unloader: default geometry plus two small geometries.
module tb_keccak_state_unloader;

   localparam int unsigned SIZE = 1600;
   localparam int unsigned WORD = 64;
   localparam int unsigned NW   = 25;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [SIZE-1:0] v_data;
   logic            v_load, ready, busy, valid, last, done;
   logic [WORD-1:0] word;

   logic [7:0] s8_data;
   logic       s8_load, s8_ready, s8_busy, s8_valid, s8_last, s8_done;
   logic [3:0] s8_word;

   logic [3:0] s4_data;
   logic       s4_load, s4_ready, s4_busy, s4_valid, s4_last, s4_done;
   logic [3:0] s4_word;

   keccak_state_unloader #(.SIZE(SIZE), .WORD(WORD)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_v_data(v_data), .i_v_load(v_load), .o_busy(busy),
      .o_v_word(word), .o_valid(valid), .i_ready(ready), .o_last(last), .o_done(done)
   );

   keccak_state_unloader #(.SIZE(8), .WORD(4)) u_s8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_v_data(s8_data), .i_v_load(s8_load), .o_busy(s8_busy),
      .o_v_word(s8_word), .o_valid(s8_valid), .i_ready(s8_ready), .o_last(s8_last),
      .o_done(s8_done)
   );

   keccak_state_unloader #(.SIZE(4), .WORD(4)) u_s4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_v_data(s4_data), .i_v_load(s4_load), .o_busy(s4_busy),
      .o_v_word(s4_word), .o_valid(s4_valid), .i_ready(s4_ready), .o_last(s4_last),
      .o_done(s4_done)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] l0;
      logic [3:0] l1;
   } s8_vec_t;

   typedef struct {
      logic [3:0] data;
      logic [3:0] l0;
   } s4_vec_t;

   s8_vec_t s8_tab[4];
   s4_vec_t s4_tab[3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: lane k of a state is simply bits [k*WORD +: WORD].
   function automatic logic [WORD-1:0] lane(input logic [SIZE-1:0] s, input int k);
      return s[k*WORD +: WORD];
   endfunction

   function automatic logic [SIZE-1:0] rand_state();
      logic [SIZE-1:0] s;
      for (int i = 0; i < SIZE / 32; i++) s[i*32 +: 32] = $urandom;
      return s;
   endfunction

   task automatic load_main(input logic [SIZE-1:0] s);
      v_load = 1'b1;
      v_data = s;
      @(negedge clk);
      v_load = 1'b0;
   endtask

   // Expects lane 0 of s presented at the current negedge.
   task automatic drain(input logic [SIZE-1:0] s, input int stall_k, input int stall_n,
                        input bit inject, input bit reload, input logic [SIZE-1:0] new_s);
      for (int k = 0; k < int'(NW); k++) begin
         if (k == stall_k) begin
            for (int j = 0; j < stall_n; j++) begin
               ready = 1'b0;
               chk($sformatf("stall_word k=%0d j=%0d", k, j), word, lane(s, k));
               chk_bit($sformatf("stall_valid k=%0d", k), valid, 1'b1);
               chk_bit($sformatf("stall_last k=%0d", k), last, (k == int'(NW) - 1));
               @(negedge clk);
            end
         end
         ready = 1'b1;
         if (inject && (k == 2 || k == int'(NW) - 1)) begin
            v_load = 1'b1;
            v_data = ~s;
         end
         chk($sformatf("word k=%0d", k), word, lane(s, k));
         chk_bit($sformatf("valid k=%0d", k), valid, 1'b1);
         chk_bit($sformatf("busy k=%0d", k), busy, 1'b1);
         chk_bit($sformatf("last k=%0d", k), last, (k == int'(NW) - 1));
         chk_bit($sformatf("no_done k=%0d", k), done, 1'b0);
         @(negedge clk);
         v_load = 1'b0;
      end
      chk_bit("done_pulse", done, 1'b1);
      chk_bit("done_valid", valid, 1'b0);
      chk_bit("done_busy", busy, 1'b0);
      if (reload) begin
         v_load = 1'b1;
         v_data = new_s;
         @(negedge clk);
         v_load = 1'b0;
         chk_bit("reload_valid", valid, 1'b1);
         chk("reload_word", word, lane(new_s, 0));
         chk_bit("reload_done_clr", done, 1'b0);
      end else begin
         @(negedge clk);
         chk_bit("done_clr", done, 1'b0);
         chk_bit("idle_valid", valid, 1'b0);
         chk_bit("idle_busy", busy, 1'b0);
      end
   endtask

   initial begin
      logic [SIZE-1:0] st_a, st_b, rs, got;
      int idx;
      bit fin;

      s8_tab[0] = '{8'hA5, 4'h5, 4'hA};
      s8_tab[1] = '{8'h3C, 4'hC, 4'h3};
      s8_tab[2] = '{8'h00, 4'h0, 4'h0};
      s8_tab[3] = '{8'hF1, 4'h1, 4'hF};
      s4_tab[0] = '{4'hC, 4'hC};
      s4_tab[1] = '{4'h7, 4'h7};
      s4_tab[2] = '{4'h0, 4'h0};

      v_data = '0; v_load = 1'b0; ready = 1'b1;
      s8_data = '0; s8_load = 1'b0; s8_ready = 1'b1;
      s4_data = '0; s4_load = 1'b0; s4_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_bit("rst_valid", valid, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_last", last, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk("rst_word", word, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < int'(NW); k++) st_a[k*WORD +: WORD] = 64'(k + 1);
      st_b = ~st_a;

      load_main(st_a);
      drain(st_a, -1, 0, 1'b0, 1'b0, '0);

      load_main(st_a);
      drain(st_a, 4, 3, 1'b0, 1'b0, '0);

      load_main(st_a);
      drain(st_a, -1, 0, 1'b1, 1'b1, st_b);
      drain(st_b, -1, 0, 1'b0, 1'b0, '0);

      // Asynchronous reset in the middle of lane 10.
      load_main(st_a);
      ready = 1'b1;
      for (int k = 0; k < 9; k++) @(negedge clk);
      chk("pre_rst_word", word, lane(st_a, 9));
      #1 rst_n = 1'b0;
      #1;
      chk_bit("midrst_valid", valid, 1'b0);
      chk_bit("midrst_last", last, 1'b0);
      chk_bit("midrst_busy", busy, 1'b0);
      chk("midrst_word", word, 64'h0);
      @(negedge clk);
      chk_bit("midrst_no_done", done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_bit("postrst_no_done", done, 1'b0);
      chk_bit("postrst_valid", valid, 1'b0);
      load_main(st_b);
      drain(st_b, -1, 0, 1'b0, 1'b0, '0);

      foreach (s8_tab[i]) begin
         s8_load = 1'b1;
         s8_data = s8_tab[i].data;
         s8_ready = 1'b1;
         @(negedge clk);
         s8_load = 1'b0;
         chk_bit($sformatf("s8_valid0 %0d", i), s8_valid, 1'b1);
         chk($sformatf("s8_lane0 %0d", i), 64'(s8_word), 64'(s8_tab[i].l0));
         chk_bit($sformatf("s8_last0 %0d", i), s8_last, 1'b0);
         @(negedge clk);
         chk($sformatf("s8_lane1 %0d", i), 64'(s8_word), 64'(s8_tab[i].l1));
         chk_bit($sformatf("s8_last1 %0d", i), s8_last, 1'b1);
         @(negedge clk);
         chk_bit($sformatf("s8_done %0d", i), s8_done, 1'b1);
         chk_bit($sformatf("s8_idle %0d", i), s8_valid, 1'b0);
         @(negedge clk);
      end

      foreach (s4_tab[i]) begin
         s4_load = 1'b1;
         s4_data = s4_tab[i].data;
         s4_ready = 1'b0;
         @(negedge clk);
         s4_load = 1'b0;
         chk_bit($sformatf("s4_valid %0d", i), s4_valid, 1'b1);
         chk($sformatf("s4_lane %0d", i), 64'(s4_word), 64'(s4_tab[i].l0));
         chk_bit($sformatf("s4_last %0d", i), s4_last, 1'b1);
         s4_ready = 1'b1;
         @(negedge clk);
         chk_bit($sformatf("s4_done %0d", i), s4_done, 1'b1);
         chk_bit($sformatf("s4_idle %0d", i), s4_valid, 1'b0);
         @(negedge clk);
      end

      for (int t = 0; t < 100; t++) begin
         rs = rand_state();
         load_main(rs);
         got = '0;
         idx = 0;
         fin = 1'b0;
         for (int cyc = 0; cyc < int'(NW) * 16 && !fin; cyc++) begin
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
               if (idx < int'(NW)) got[idx*WORD +: WORD] = word;
               idx++;
               if (last) fin = 1'b1;
            end
            @(negedge clk);
         end
         ready = 1'b1;
         chk_bit($sformatf("rnd_finished t=%0d", t), fin, 1'b1);
         chk($sformatf("rnd_count t=%0d", t), 64'(idx), 64'(NW));
         chk_bit($sformatf("rnd_done t=%0d", t), done, 1'b1);
         checks++;
         if (got !== rs) begin
            errors++;
            for (int k = 0; k < int'(NW); k++) begin
               if (lane(got, k) !== lane(rs, k)) begin
                  $display("FAIL rnd_reassemble t=%0d lane %0d: got %0h expected %0h",
                           t, k, lane(got, k), lane(rs, k));
                  break;
               end
            end
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keccak_state_unloader.md
Name: keccak_state_unloader

Overview:
Parallel-in, serial-out reader for a wide Keccak state register. It captures a full SIZE-bit state in one load cycle, then drains it as WORD-bit lanes over a valid/ready stream, least-significant lane first. It sits between the permutation core's state register and downstream consumers such as the hash-output packer.

Parameters:
SIZE, 1600, total state width in bits; must be an integer multiple of WORD.
WORD, 64, output lane width in bits.
NWORDS (localparam), SIZE/WORD, number of lanes per state (25 at defaults).
CW (localparam), max(1,$clog2(NWORDS)), lane-counter width.

Ports:
i_clk  in  1  rising-edge clock.
i_rst_n  in  1  asynchronous active-low reset.
i_v_data  in  SIZE  state to unload; sampled only on an accepted load.
i_v_load  in  1  load request; accepted only in IDLE.
o_busy  out  1  high from the cycle after an accepted load until the cycle after the final lane transfer; loads are refused while high.
o_v_word  out  WORD  current lane.
o_valid  out  1  o_v_word is valid.
i_ready  in  1  consumer ready; a transfer occurs when o_valid and i_ready are both high.
o_last  out  1  high with o_valid when the final lane (index NWORDS-1) is presented.
o_done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (async assert, synchronous deassert at the block boundary): state=IDLE, internal shift register=0, counter=0. o_v_word, o_valid, o_last, o_done and o_busy are all 0. Outputs drop immediately on assert, including mid-stream; the partial stream is abandoned, with no o_done.
- FSM states: IDLE, SEND.
- IDLE, i_v_load=1: capture i_v_data into the shift register, clear the counter, go to SEND. One cycle of latency: lane 0 (bits WORD-1:0) appears with o_valid=1 on the next cycle.
- IDLE, i_v_load=0: hold. o_valid=0.
- SEND:
  - o_valid=1, o_busy=1, o_v_word = low WORD bits of the shift register.
  - o_last = (counter == NWORDS-1).
  - On transfer, when counter < NWORDS-1: shift right by WORD (zero-fill the top) and increment the counter.
  - On transfer, when counter == NWORDS-1: go to IDLE and pulse o_done for the next cycle; o_valid=0 in that cycle.
- Backpressure: while o_valid=1 and i_ready=0, o_v_word, o_last and the counter hold stable. No lane is skipped or duplicated.
- i_v_load in SEND, including the final-transfer cycle: ignored, no capture. The earliest re-load is accepted in the o_done cycle, when state=IDLE; its lane 0 appears one cycle later.
- i_v_data changes after capture do not affect the stream.
- NWORDS=1: the single lane carries o_last=1 on its first presentation.
- Counter never exceeds NWORDS-1; no wrap-around is possible.
- Throughput: one lane per cycle with i_ready held high. Load to o_done takes NWORDS+1 cycles.

Decomposition:
- Shared Keccak package: state-encoding constants (IDLE=1'b0, SEND=1'b1), default SIZE/WORD values, and the lane-count function (SIZE/WORD).
- Single flat module. The lane counter is small enough to stay inline; no sub-module is natural.

Test Plan:
- Defaults; load a state where lane k = k+1; i_ready=1 -> o_v_word = 1,2,...,25 on consecutive cycles; o_last only with 25; o_done exactly one cycle after it; o_busy low afterwards.
- Same state; i_ready=0 for 3 cycles while lane 5 is presented -> o_v_word stays 5 for 4 cycles; next lane is 6; total of 25 transfers.
- Assert i_v_load with a different state during lanes 3 and 25 -> ignored, stream unchanged. Assert load in the o_done cycle -> accepted; the new lane 0 appears on the following cycle.
- Drop i_rst_n mid-clock while lane 10 is presented -> o_valid/o_last/o_busy/o_v_word go to 0 before the next edge; no o_done; a fresh load then streams from lane 0.
- SIZE=8, WORD=4, load 8'hA5 -> lanes 4'h5, then 4'hA with o_last. SIZE=4, WORD=4, load 4'hC -> a single lane 4'hC with o_last=1.
- Random i_ready, 100 random states -> collected lanes reassemble to the loaded state exactly.
